l2_req_noc_packer: RTL and testbench

- Downstream stage of the L2 core's request-out channel. Accepts one coherence request per handshake (GetS, GetM, PutS, PutM) and serializes it into NoC flits on the coherence request plane.
- Each packet is a header flit, then an address flit, then, for PutM only, the line data words, lowest word first.
- Holds one request in a holding register and supports back-to-back packets without bubbles.

---
 rtl/l2_req_noc_packer_if.sv | 34 +++
 rtl/l2_req_noc_packer.sv | 69 ++++++
 tb/tb_l2_req_noc_packer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/l2_req_noc_packer_if.sv
// l2_req_noc_packer_if: request-in handshake (req_*), static tile ids, flit-out handshake (flit_*) and pkt_cnt of the L2 request NoC packer
interface l2_req_noc_packer_if #(
  parameter int LINE_ADDR_W    = 28,
  parameter int WORD_W         = 64,
  parameter int WORDS_PER_LINE = 2,
  parameter int HPROT_W        = 2,
  parameter int TILE_ID_W      = 3
);
  logic                             req_valid;
  logic                             req_ready;
  logic [1:0]                       req_coh_msg;
  logic [HPROT_W-1:0]               req_hprot;
  logic [LINE_ADDR_W-1:0]           req_addr;
  logic [WORD_W*WORDS_PER_LINE-1:0] req_line;
  logic [TILE_ID_W-1:0]             local_x;
  logic [TILE_ID_W-1:0]             local_y;
  logic [TILE_ID_W-1:0]             home_x;
  logic [TILE_ID_W-1:0]             home_y;
  logic                             flit_valid;
  logic                             flit_ready;
  logic [WORD_W-1:0]                flit_data;
  logic                             flit_tail;
  logic [15:0]                      pkt_cnt;
  modport slave (
    input  req_valid, req_coh_msg, req_hprot, req_addr, req_line,
    input  local_x, local_y, home_x, home_y, flit_ready,
    output req_ready, flit_valid, flit_data, flit_tail, pkt_cnt
  );
  modport master (
    output req_valid, req_coh_msg, req_hprot, req_addr, req_line,
    output local_x, local_y, home_x, home_y, flit_ready,
    input  req_ready, flit_valid, flit_data, flit_tail, pkt_cnt
  );
endinterface

// File: rtl/l2_req_noc_packer.sv
// l2_req_noc_packer: serializes one coherence request (bus.req_*) into header/address/[PutM data] NoC flits (bus.flit_*), counting packets in bus.pkt_cnt; clk, sync active-high rst
module l2_req_noc_packer #(
  parameter int LINE_ADDR_W    = 28,
  parameter int OFFSET_W       = 4,
  parameter int WORD_W         = 64,
  parameter int WORDS_PER_LINE = 2,
  parameter int HPROT_W        = 2,
  parameter int TILE_ID_W      = 3
) (
  input logic clk,
  input logic rst,
  l2_req_noc_packer_if.slave bus
);
  localparam int CW = $clog2(WORDS_PER_LINE);
  localparam int HDR_W = 4*TILE_ID_W + 5 + HPROT_W;
  localparam logic [1:0] PUTM = 2'd3;
  typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_e;
  state_e                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [1:0]                       msg_q;
  logic [HPROT_W-1:0]               hprot_q;
  logic [LINE_ADDR_W-1:0]           addr_q;
  logic [WORD_W*WORDS_PER_LINE-1:0] line_q;
  logic [15:0]                      pkt_cnt_q;
  logic [WORD_W-1:0]                hdr_flit, addr_flit, word_flit;
  logic                             tail, flit_hs, tail_hs, accept;
  assign hdr_flit  = {{(WORD_W-HDR_W){1'b0}}, hprot_q, 3'b000, msg_q,
                      bus.home_y, bus.home_x, bus.local_y, bus.local_x};
  assign addr_flit = {{(WORD_W-LINE_ADDR_W-OFFSET_W){1'b0}}, addr_q, {OFFSET_W{1'b0}}};
  assign word_flit = line_q[cnt_q*WORD_W +: WORD_W];
  always_comb begin
    tail    = (state_q == ADDR && msg_q != PUTM) ||
              (state_q == DATA && cnt_q == CW'(WORDS_PER_LINE-1));
    flit_hs = state_q != IDLE && bus.flit_ready;
    tail_hs = flit_hs && tail;
    accept  = bus.req_valid && (state_q == IDLE || tail_hs);
    state_d = accept ? HDR : tail_hs ? IDLE : !flit_hs ? state_q :
              state_q == HDR ? ADDR : DATA;
    cnt_d   = !flit_hs ? cnt_q : state_q == ADDR ? '0 :
              state_q == DATA ? cnt_q + 1'b1 : cnt_q;
  end
  assign bus.req_ready  = state_q == IDLE || tail_hs;
  assign bus.flit_valid = state_q != IDLE;
  assign bus.flit_tail  = tail;
  assign bus.flit_data  = state_q == HDR ? hdr_flit : state_q == ADDR ? addr_flit :
                          state_q == DATA ? word_flit : '0;
  assign bus.pkt_cnt    = pkt_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      msg_q     <= '0;
      hprot_q   <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        msg_q   <= bus.req_coh_msg;
        hprot_q <= bus.req_hprot;
        addr_q  <= bus.req_addr;
        line_q  <= bus.req_line;
      end
      if (tail_hs) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_l2_req_noc_packer.sv
// tb_l2_req_noc_packer: scoreboard bench for l2_req_noc_packer
module tb_l2_req_noc_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  logic [15:0] exp_pkt = '0;
  logic [64:0] q[$];
  logic [64:0] mon_e;
  logic hold = 1'b0;
  logic [64:0] hold_v;
  l2_req_noc_packer_if bus();
  l2_req_noc_packer dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] hdr(input logic [1:0] m, input logic [1:0] hp);
    return {45'b0, hp, 3'b000, m, bus.home_y, bus.home_x, bus.local_y, bus.local_x};
  endfunction
  always @(negedge clk) begin
    if (rst) hold = 1'b0;
    else begin
      chk("pkt_cnt", bus.pkt_cnt, exp_pkt);
      if (!bus.flit_valid) chk("tail_idle", bus.flit_tail, 0);
      if (hold) begin
        chk("hold_valid", bus.flit_valid, 1);
        chk("hold_data", bus.flit_data, hold_v[63:0]);
        chk("hold_tail", bus.flit_tail, hold_v[64]);
      end
      hold = bus.flit_valid && !bus.flit_ready;
      hold_v = {bus.flit_tail, bus.flit_data};
      if (bus.flit_valid && bus.flit_ready) begin
        if (q.size() == 0) chk("unexpected_flit", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("flit_data", bus.flit_data, mon_e[63:0]);
          chk("flit_tail", bus.flit_tail, mon_e[64]);
          if (bus.flit_tail) exp_pkt = exp_pkt + 16'd1;
        end
      end
    end
  end
  task automatic send(input logic [1:0] m, input logic [1:0] hp, input logic [27:0] a, input logic [127:0] l);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_coh_msg = m;
    bus.req_hprot = hp;
    bus.req_addr = a;
    bus.req_line = l;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 100), 1);
    q.push_back({1'b0, hdr(m, hp)});
    q.push_back({m != 2'd3, {32'b0, a, 4'b0}});
    if (m == 2'd3) for (int i = 0; i < 2; i++) q.push_back({i == 1, l[i*64 +: 64]});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_line = '1;
    bus.req_addr = '1;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.flit_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 200), 1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    q.delete();
    exp_pkt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_coh_msg = '0;
    bus.req_hprot = '0;
    bus.req_addr = '0;
    bus.req_line = '0;
    bus.flit_ready = 1'b1;
    bus.local_x = 3'd1;
    bus.local_y = 3'd2;
    bus.home_x = 3'd3;
    bus.home_y = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.flit_valid, 0);
    chk("rst_tail", bus.flit_tail, 0);
    chk("rst_data", bus.flit_data, 0);
    chk("rst_pkt", bus.pkt_cnt, 0);
    rst = 1'b0;
    chk("rst_ready", bus.req_ready, 1);
    send(2'd0, 2'd1, 28'h0000ABC, '0);
    chk("gets_hdr_valid", bus.flit_valid, 1);
    chk("gets_hdr", bus.flit_data, 64'h200D1);
    chk("gets_hdr_tail", bus.flit_tail, 0);
    @(posedge clk);
    #1;
    chk("gets_addr", bus.flit_data, 64'hABC0);
    chk("gets_addr_tail", bus.flit_tail, 1);
    @(posedge clk);
    #1;
    chk("gets_done_valid", bus.flit_valid, 0);
    chk("gets_pkt", bus.pkt_cnt, 1);
    send(2'd3, 2'd2, 28'h0000123, {64'h2222, 64'h1111});
    drain();
    chk("putm_pkt", bus.pkt_cnt, 2);
    send(2'd3, 2'd0, 28'h0000456, {64'h2222, 64'h1111});
    @(posedge clk);
    #1;
    bus.flit_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", bus.flit_valid, 1);
      chk("bp_data", bus.flit_data, 64'h4560);
      chk("bp_tail", bus.flit_tail, 0);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.flit_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_data_follow", bus.flit_data, 64'h1111);
    drain();
    do_reset();
    send(2'd1, 2'd3, 28'h00000AA, '0);
    t0 = cyc;
    send(2'd2, 2'd1, 28'h00000BB, '0);
    chk("b2b_gap", 64'(cyc - t0), 2);
    chk("b2b_valid", bus.flit_valid, 1);
    chk("b2b_hdr", bus.flit_data, hdr(2'd2, 2'd1));
    drain();
    chk("b2b_pkt", bus.pkt_cnt, 2);
    send(2'd3, 2'd3, 28'h0000777, {64'hBBBB, 64'hAAAA});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_word0", bus.flit_data, 64'hAAAA);
    rst = 1'b1;
    q.delete();
    exp_pkt = '0;
    @(posedge clk);
    #1;
    chk("mid_valid", bus.flit_valid, 0);
    chk("mid_tail", bus.flit_tail, 0);
    chk("mid_pkt", bus.pkt_cnt, 0);
    rst = 1'b0;
    chk("mid_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    chk("mid_idle", bus.flit_valid, 0);
    force dut.pkt_cnt_q = 16'hFFFE;
    exp_pkt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.pkt_cnt_q;
    send(2'd0, 2'd0, 28'h0000001, '0);
    send(2'd0, 2'd0, 28'h0000002, '0);
    drain();
    chk("wrap_pkt", bus.pkt_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
